program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 95 +++++++++
 tb/tb_program_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Bundled handshake, memory-write and status signals of the program loader.
// The slave side belongs to the loader; the master side belongs to the host/bench.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] address;
  logic              write_enable;
  logic [7:0]        write_data;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [7:0]        checksum;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, address, write_enable, write_data,
           cpu_reset, busy, done, error, checksum
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, address, write_enable, write_data,
           cpu_reset, busy, done, error, checksum
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed byte frame into instruction memory
// and releases the processor from reset only after a frame verifies.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input logic            clk,
  input logic            reset,
  program_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        count;
  logic [8:0]        length;
  logic [7:0]        sum;
  logic [7:0]        chk_total;
  logic              accepting;
  logic              xfer;
  logic              load;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;

  assign accepting = (state == LEN) || (state == DATA) || (state == CHK);
  assign xfer      = bus.in_valid && accepting;
  assign chk_total = sum + bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Start is only honoured while no frame is in progress.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_next = LEN;
          load       = 1'b1;
        end
      end
      LEN:  if (xfer) state_next = DATA;
      DATA: if (xfer && ((count + 9'd1) == length)) state_next = CHK;
      CHK:  if (xfer) state_next = (chk_total == 8'd0) ? DONE : ERR;
      default: state_next = IDLE;
    endcase
  end

  // The memory write is registered, so it appears the cycle after the transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      count   <= '0;
      length  <= '0;
      sum     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (load) begin
        ptr    <= '0;
        count  <= '0;
        sum    <= '0;
        addr_q <= '0;
      end else if (xfer) begin
        case (state)
          LEN: length <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          DATA: begin
            we_q    <= 1'b1;
            addr_q  <= ptr;
            wdata_q <= bus.in_data;
            ptr     <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            count   <= count + 9'd1;
            sum     <= sum + bus.in_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = accepting;
  assign bus.busy         = accepting;
  assign bus.address      = addr_q;
  assign bus.write_enable = we_q;
  assign bus.write_data   = wdata_q;
  assign bus.checksum     = sum;
  assign bus.cpu_reset    = (state != DONE);
  assign bus.done         = (state == DONE);
  assign bus.error        = (state == ERR);
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as
// bytes are streamed, and a negedge monitor checks every write the DUT makes.
module tb_program_loader;
  logic clk;
  logic reset;
  int   checks;
  int   passed;

  logic [7:0]  frame[$];
  logic [15:0] exp_q[$];

  program_loader_if #(.ADDR_W(8)) bus ();

  program_loader #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.address, bus.write_data);
      end else begin
        check_output("write", {bus.address, bus.write_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      $display("[TB] FAIL handshake_timeout: got in_ready 0, expected 1");
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Streams the frame in 'frame'; bytes 1..n-2 are payload and expected as writes.
  task automatic apply_stimulus(input bit stall);
    for (int i = 0; i < frame.size(); i++) begin
      if (i > 0 && i < frame.size() - 1)
        exp_q.push_back({8'(i - 1), frame[i]});
      send_byte(frame[i]);
      if (stall) tick();
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic cr, input logic [7:0] cs);
    check_output({tag, "_done"}, bus.done, d);
    check_output({tag, "_error"}, bus.error, e);
    check_output({tag, "_cpu_reset"}, bus.cpu_reset, cr);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_checksum"}, bus.checksum, cs);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"}, bus.in_ready, 0);
    check_output({tag, "_address"}, bus.address, 0);
    check_output({tag, "_write_enable"}, bus.write_enable, 0);
    check_output({tag, "_write_data"}, bus.write_data, 0);
    check_status(tag, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");

    $display("[TB] good frame");
    apply_start();
    check_output("len_busy", bus.busy, 1);
    check_output("len_in_ready", bus.in_ready, 1);
    frame = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    apply_stimulus(1'b0);
    check_status("good", 1'b1, 1'b0, 1'b0, 8'h60);

    $display("[TB] reload from DONE");
    apply_start();
    check_output("reload_cpu_reset", bus.cpu_reset, 1);
    check_output("reload_done", bus.done, 0);
    check_output("reload_checksum", bus.checksum, 0);

    $display("[TB] bad checksum then good frame");
    frame = '{8'h02, 8'h01, 8'h02, 8'h00};
    apply_stimulus(1'b0);
    check_status("bad", 1'b0, 1'b1, 1'b1, 8'h03);
    tick();
    check_output("bad_sticky_error", bus.error, 1);
    apply_start();
    frame = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    apply_stimulus(1'b0);
    check_status("recover", 1'b1, 1'b0, 1'b0, 8'h60);

    $display("[TB] stalled frame");
    apply_start();
    apply_stimulus(1'b1);
    check_status("stall", 1'b1, 1'b0, 1'b0, 8'h60);

    $display("[TB] max length frame");
    apply_start();
    frame = {};
    frame.push_back(8'h00);
    for (int i = 0; i < 256; i++) frame.push_back(8'h01);
    frame.push_back(8'h00);
    apply_stimulus(1'b0);
    check_status("max", 1'b1, 1'b0, 1'b0, 8'h00);

    $display("[TB] start during busy");
    apply_start();
    send_byte(8'h03);
    exp_q.push_back({8'h00, 8'h11});
    bus.start = 1'b1;
    send_byte(8'h11);
    bus.start = 1'b0;
    check_output("busy_start_busy", bus.busy, 1);
    exp_q.push_back({8'h01, 8'h22});
    send_byte(8'h22);
    exp_q.push_back({8'h02, 8'h33});
    send_byte(8'h33);
    send_byte(8'h9A);
    check_status("busy_start", 1'b1, 1'b0, 1'b0, 8'h66);

    $display("[TB] reset mid-frame with start");
    apply_start();
    send_byte(8'h03);
    exp_q.push_back({8'h00, 8'h10});
    send_byte(8'h10);
    exp_q.push_back({8'h01, 8'h20});
    send_byte(8'h20);
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h30;
    tick();
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_values("midreset");
    tick();
    tick();
    check_output("midreset_idle_busy", bus.busy, 0);
    check_output("midreset_idle_in_ready", bus.in_ready, 0);
    check_output("midreset_idle_cpu_reset", bus.cpu_reset, 1);

    tick();
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
